// File: rtl/fpu_mul_sequencer.sv
// Four-pass 32x32 unsigned multiply through an external 16x16 multiplier, returning the fixed-point slice.
// Optional FPU_MUL_SATURATE_EN: clamp result to all-ones whenever overflow is flagged.
module fpu_mul_sequencer #(
  parameter int WIDTH = 32,
  parameter int FBITS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  output logic [15:0]      mult_op_a,
  output logic [15:0]      mult_op_b,
  input  logic [31:0]      mult_product,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             ready,
  output logic             overflow
);

  typedef enum logic [2:0] {IDLE, PP0, PP1, PP2, PP3, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a, b;
  logic [63:0]      acc, pp_ext, acc_sum;
  logic             accept, ovf_next;
  logic [WIDTH-1:0] res_next;

  assign accept = start && (state == IDLE || state == DONE);
  assign busy   = (state == PP0) || (state == PP1) || (state == PP2) || (state == PP3);
  assign ready  = (state == DONE);

  always_comb begin
    state_next = state;
    mult_op_a  = 16'h0;
    mult_op_b  = 16'h0;
    pp_ext     = 64'h0;
    case (state)
      IDLE: if (start) state_next = PP0;
      PP0: begin
        mult_op_a  = a[15:0];
        mult_op_b  = b[15:0];
        pp_ext     = {32'h0, mult_product};
        state_next = PP1;
      end
      PP1: begin
        mult_op_a  = a[31:16];
        mult_op_b  = b[15:0];
        pp_ext     = {16'h0, mult_product, 16'h0};
        state_next = PP2;
      end
      PP2: begin
        mult_op_a  = a[15:0];
        mult_op_b  = b[31:16];
        pp_ext     = {16'h0, mult_product, 16'h0};
        state_next = PP3;
      end
      PP3: begin
        mult_op_a  = a[31:16];
        mult_op_b  = b[31:16];
        pp_ext     = {mult_product, 32'h0};
        state_next = DONE;
      end
      DONE: state_next = start ? PP0 : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // acc_sum in PP3 is the exact 64-bit product
  assign acc_sum  = acc + pp_ext;
  assign ovf_next = |acc_sum[63:WIDTH+FBITS];
`ifdef FPU_MUL_SATURATE_EN
  assign res_next = ovf_next ? {WIDTH{1'b1}} : acc_sum[WIDTH+FBITS-1:FBITS];
`else
  assign res_next = acc_sum[WIDTH+FBITS-1:FBITS];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      a        <= '0;
      b        <= '0;
      acc      <= 64'h0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        a   <= operand_1;
        b   <= operand_2;
        acc <= 64'h0;
      end else if (busy) begin
        acc <= acc_sum;
      end
      if (state == PP3) begin
        result   <= res_next;
        overflow <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_fpu_mul_sequencer.sv
// Directed bench for fpu_mul_sequencer: vector table plus back-to-back and mid-op reset sequences.
module tb_fpu_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] operand_1, operand_2;
  logic [15:0] mult_op_a, mult_op_b;
  logic [31:0] mult_product;
  logic        busy, ready, overflow;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // behavioural stand-in for the shared 16x16 multiplier
  assign mult_product = {16'h0, mult_op_a} * {16'h0, mult_op_b};

  fpu_mul_sequencer #(.WIDTH(32), .FBITS(10)) dut (
    .clk(clk), .reset(reset), .start(start),
    .operand_1(operand_1), .operand_2(operand_2),
    .mult_op_a(mult_op_a), .mult_op_b(mult_op_b), .mult_product(mult_product),
    .busy(busy), .result(result), .ready(ready), .overflow(overflow)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  vec_t vecs[4];

  initial begin
    logic [31:0] sat_res;
    vec_t        seq[3];
    logic [15:0] ea[4], eb[4];

`ifdef FPU_MUL_SATURATE_EN
    sat_res = 32'hFFFF_FFFF;
`else
    sat_res = 32'hFF80_0000;
`endif
    vecs[0] = '{32'h0000_0400, 32'h0000_0400, 32'h0000_0400, 1'b0};
    vecs[1] = '{32'h0000_0C00, 32'h0000_0200, 32'h0000_0600, 1'b0};
    vecs[2] = '{32'h0001_0000, 32'h0001_0000, 32'h0040_0000, 1'b0};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, sat_res,       1'b1};

    reset = 1'b1; start = 1'b0; operand_1 = '0; operand_2 = '0;
    tick(); tick();
    chk("rst_busy",   busy, 0);
    chk("rst_ready",  ready, 0);
    chk("rst_result", result, 0);
    chk("rst_ovf",    overflow, 0);
    chk("rst_opa",    mult_op_a, 0);
    chk("rst_opb",    mult_op_b, 0);
    reset = 1'b0;
    tick();

    for (int v = 0; v < 4; v++) begin
      ea = '{vecs[v].a[15:0], vecs[v].a[31:16], vecs[v].a[15:0], vecs[v].a[31:16]};
      eb = '{vecs[v].b[15:0], vecs[v].b[15:0], vecs[v].b[31:16], vecs[v].b[31:16]};
      operand_1 = vecs[v].a; operand_2 = vecs[v].b; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 4; c++) begin
        chk($sformatf("v%0d_busy_c%0d", v, c),  busy, 1);
        chk($sformatf("v%0d_ready_c%0d", v, c), ready, 0);
        chk($sformatf("v%0d_opa_pp%0d", v, c-1), mult_op_a, ea[c-1]);
        chk($sformatf("v%0d_opb_pp%0d", v, c-1), mult_op_b, eb[c-1]);
        if (c == 2) begin
          // a stray start while busy must not disturb the operation
          operand_1 = 32'h1234_5678; operand_2 = 32'h9ABC_DEF0; start = 1'b1;
        end else begin
          start = 1'b0;
        end
        tick();
      end
      chk($sformatf("v%0d_ready_c5", v),  ready, 1);
      chk($sformatf("v%0d_busy_c5", v),   busy, 0);
      chk($sformatf("v%0d_result", v),    result, vecs[v].res);
      chk($sformatf("v%0d_ovf", v),       overflow, vecs[v].ovf);
      tick();
      chk($sformatf("v%0d_ready_c6", v),  ready, 0);
      chk($sformatf("v%0d_busy_c6", v),   busy, 0);
      tick();
      chk($sformatf("v%0d_result_hold", v), result, vecs[v].res);
      chk($sformatf("v%0d_ovf_hold", v),    overflow, vecs[v].ovf);
    end

    // start held high: DONE->PP0 back-to-back, ready at cycles 5, 10, 15
    seq[0] = vecs[0]; seq[1] = vecs[1]; seq[2] = vecs[2];
    operand_1 = seq[0].a; operand_2 = seq[0].b; start = 1'b1;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      tick();
      if (cyc % 5 == 0) begin
        chk($sformatf("b2b_ready_c%0d", cyc),  ready, 1);
        chk($sformatf("b2b_busy_c%0d", cyc),   busy, 0);
        chk($sformatf("b2b_result_c%0d", cyc), result, seq[cyc/5-1].res);
        if (cyc < 15) begin
          operand_1 = seq[cyc/5].a; operand_2 = seq[cyc/5].b;
        end
      end else begin
        chk($sformatf("b2b_ready_c%0d", cyc), ready, 0);
        chk($sformatf("b2b_busy_c%0d", cyc),  busy, 1);
        operand_1 = 32'hDEAD_BEEF; operand_2 = 32'hCAFE_F00D;
      end
    end
    start = 1'b0;
    tick();
    chk("b2b_end_ready", ready, 0);
    chk("b2b_end_busy",  busy, 0);

    // reset landing in PP2 discards the operation
    operand_1 = vecs[3].a; operand_2 = vecs[3].b; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("rmid_busy_pp2", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rmid_busy",   busy, 0);
    chk("rmid_ready",  ready, 0);
    chk("rmid_result", result, 0);
    chk("rmid_ovf",    overflow, 0);
    chk("rmid_opa",    mult_op_a, 0);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("rmid_noready_%0d", c), ready, 0);
      chk($sformatf("rmid_nobusy_%0d", c),  busy, 0);
    end
    chk("rmid_result_after", result, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
